ahf_slave_link: RTL and testbench
=================================

Name: ahf_slave_link

Overview:
Master-side link controller that sits directly upstream of the RISC521 slave core. It drives the slave's Data_in/Write/Read pins and consumes its Data_out/Done_out pins. It buffers master-to-slave words in a TX FIFO and slave-to-master words in an RX FIFO. It runs the one-cycle Write/Read strobes that release the slave's I/O stall, and flags a handshake timeout.

Parameters:
DEPTH, 8, entries per FIFO; must be a power of 2.
AW, 3, log2(DEPTH).
TIMEOUT, 15, maximum cycles to wait for Slv_done to drop after a strobe.

Ports:
Clk_pin  in  1  single clock; all state updates on the rising edge.
Reset_pin  in  1  synchronous, active-high reset.
Tx_push  in  1  master pushes Tx_data into the TX FIFO.
Tx_data  in  14  word destined for the slave.
Tx_full  out  1  TX FIFO full.
Tx_count  out  AW+1  TX occupancy.
Rx_pop  in  1  master pops the RX FIFO head.
Rx_data  out  14  RX head word (first-word-fall-through); 0 when empty.
Rx_empty  out  1  RX FIFO empty.
Rx_count  out  AW+1  RX occupancy.
Slv_done  in  1  slave Done_out.
Slv_dir  in  1  slave request type: 0 = slave LD from I/O (wants data); 1 = slave ST to I/O (Slv_data valid).
Slv_data  in  14  slave Data_out.
Slv_wdata  out  14  to slave Data_in.
Slv_write  out  1  to slave Write.
Slv_read  out  1  to slave Read.
Busy  out  1  FSM is not in IDLE.
Err  out  1  sticky handshake-timeout flag.
Err_clr  in  1  clears Err.

Behaviour:
- Reset (Reset_pin=1 at the clock edge):
  - State goes to IDLE; both FIFOs are emptied (pointers and counts 0).
  - Slv_wdata, Slv_write, Slv_read, Busy and Err go to 0; Tx_full=0, Rx_empty=1, timer=0.
  - Reset mid-handshake aborts the transfer; any popped TX word is lost.
- FIFOs:
  - Circular buffers with AW-bit pointers that wrap modulo DEPTH; counts run 0..DEPTH.
  - Push while full is ignored, and so is pop while empty. The count is unchanged in both cases.
  - Simultaneous push and pop on the same FIFO is legal when it is neither full nor empty. Both take effect and the count is unchanged.
  - On an empty FIFO, a simultaneous push and pop: the push happens, the pop is ignored.
  - On a full FIFO, a simultaneous push and pop: the pop happens, the push is ignored.
- FSM states: IDLE, STROBE, WAIT_DROP.
- IDLE:
  - Slv_done=1, Slv_dir=0 and TX non-empty: pop the TX head into Slv_wdata, set Slv_write=1, go to STROBE.
  - Slv_done=1, Slv_dir=1 and RX not full: push Slv_data into RX, set Slv_read=1, go to STROBE.
  - Otherwise stay in IDLE. The slave keeps stalling, which is the backpressure path.
  - Slv_data is captured at the same edge that samples Slv_done=1.
- STROBE:
  - Slv_write/Slv_read are high for exactly one cycle.
  - At the next edge: clear the strobes, clear the timer, go to WAIT_DROP.
  - Slv_wdata holds its value until the next TX pop.
- WAIT_DROP:
  - Slv_done=0: go to IDLE.
  - Otherwise the timer increments; when it reaches TIMEOUT, set Err=1 and go to IDLE.
  - A new request is never accepted until Slv_done has been seen low, or the timeout has fired.
- Latency: Slv_done sampled high at edge N leads to a strobe high in cycle N+1. Minimum transfer is 3 cycles per word (IDLE, STROBE, WAIT_DROP).
- Master-side FIFO activity (push TX, pop RX) proceeds concurrently with the FSM. It may collide with the FSM's pop TX / push RX on the same edge, following the FIFO rules above.
- Err: if Err_clr=1 and a new timeout occur on the same edge, the set wins.
- Busy = (state != IDLE).

Test Plan:
- Reset check: after reset, Tx_count=0, Rx_empty=1, Rx_data=0, all strobes 0, Err=0, Busy=0.
- TX path: push 0x1234 and 0x0ABC, then hold Slv_dir=0 with Slv_done=1 for 1 cycle, then Slv_done=0 -> one-cycle Slv_write with Slv_wdata=0x1234, Tx_count=1. Repeat -> Slv_wdata=0x0ABC, Tx_count=0.
- RX path: Slv_dir=1, Slv_data=0x3F0F, Slv_done pulse -> one-cycle Slv_read, Rx_data=0x3F0F, Rx_count=1. Rx_pop -> Rx_empty=1.
- Backpressure: TX empty with Slv_done=1, Slv_dir=0 held for 20 cycles -> no strobe, Busy=0. Push 0x0005 -> Slv_write asserts 2 cycles after the push edge with Slv_wdata=0x0005.
- Full/wrap: push 9 words into TX (DEPTH=8) -> Tx_full=1, ninth word dropped. Drain all 8 via the slave handshake -> words 1..8 emerge in order across the pointer wrap.
- Timeout: after a strobe, hold Slv_done=1 -> Err=1 exactly 15 cycles after entering WAIT_DROP, FSM back to IDLE. Assert Err_clr -> Err=0.

Source files
------------

// File: rtl/ahf_slave_link.sv
// ---------------------------------------------------------------------------
// ahf_slave_link
//
// Master-side link controller sitting directly upstream of the RISC521 slave
// core. Master-to-slave words are buffered in a TX FIFO and slave-to-master
// words in an RX FIFO. A three-state FSM (IDLE -> STROBE -> WAIT_DROP) issues
// the one-cycle Write/Read strobes that release the slave's I/O stall. It
// raises a sticky error if the slave does not drop Done within TIMEOUT cycles.
//
// Handshake semantics (master side): a TX push is accepted on a rising edge
// where Tx_push=1 and the TX FIFO is not full. An RX pop is accepted on a
// rising edge where Rx_pop=1 and the RX FIFO is not empty. Any other push or
// pop is silently ignored. Rx_data is first-word-fall-through and reads 0
// while the RX FIFO is empty.
//
// Ports:
//   Clk_pin, Reset_pin       clock, synchronous active-high reset
//   Tx_push, Tx_data         master write into TX FIFO
//   Tx_full, Tx_count        TX FIFO status
//   Rx_pop, Rx_data          master read from RX FIFO (FWFT head)
//   Rx_empty, Rx_count       RX FIFO status
//   Slv_done, Slv_dir        slave Done_out and request type (0=LD, 1=ST)
//   Slv_data                 slave Data_out
//   Slv_wdata                slave Data_in (held until next TX pop)
//   Slv_write, Slv_read      one-cycle strobes to the slave
//   Busy                     FSM not in IDLE
//   Err, Err_clr             sticky timeout flag and its clear
//   Dbg_state                current FSM state encoding
// ---------------------------------------------------------------------------
module ahf_slave_link #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic          Clk_pin,
    input  logic          Reset_pin,
    input  logic          Tx_push,
    input  logic [13:0]   Tx_data,
    output logic          Tx_full,
    output logic [AW:0]   Tx_count,
    input  logic          Rx_pop,
    output logic [13:0]   Rx_data,
    output logic          Rx_empty,
    output logic [AW:0]   Rx_count,
    input  logic          Slv_done,
    input  logic          Slv_dir,
    input  logic [13:0]   Slv_data,
    output logic [13:0]   Slv_wdata,
    output logic          Slv_write,
    output logic          Slv_read,
    output logic          Busy,
    output logic          Err,
    input  logic          Err_clr,
    output logic [1:0]    Dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STROBE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // FIFO storage and pointers
    logic [13:0]   tx_mem_q [DEPTH];
    logic [13:0]   rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [AW:0]   tx_cnt_q, rx_cnt_q;

    // FSM and output registers
    logic [1:0]    state_q, state_d;
    logic [13:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic          read_q, read_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_push_eff, tx_pop_fsm, rx_push_fsm, rx_pop_eff;
    logic [TW-1:0] timer_inc;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);

    // A push is dropped when full and a pop when empty; with these two gates
    // the simultaneous push/pop corner cases resolve as required.
    assign tx_push_eff = Tx_push && !tx_full;
    assign rx_pop_eff  = Rx_pop && !rx_empty;

    assign timer_inc = timer_q + TW'(1);

    // ------------------------------------------------------------------
    // FSM next-state logic. The FSM pops TX / pushes RX only when the
    // corresponding FIFO can accept it, so both strobes are effective.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        write_d     = 1'b0;
        read_d      = 1'b0;
        timer_d     = timer_q;
        err_d       = err_q;
        tx_pop_fsm  = 1'b0;
        rx_push_fsm = 1'b0;

        if (Err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (Slv_done) begin
                    if (!Slv_dir && !tx_empty) begin
                        tx_pop_fsm = 1'b1;
                        wdata_d    = tx_mem_q[tx_rd_q];
                        write_d    = 1'b1;
                        state_d    = S_STROBE;
                    end else if (Slv_dir && !rx_full) begin
                        rx_push_fsm = 1'b1;
                        read_d      = 1'b1;
                        state_d     = S_STROBE;
                    end
                end
            end
            S_STROBE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!Slv_done) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_inc;
                    // A timeout on the same edge as Err_clr must win.
                    if (timer_inc == TW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk_pin) begin
        if (Reset_pin) begin
            state_q  <= S_IDLE;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            read_q  <= read_d;
            timer_q <= timer_d;
            err_q   <= err_d;

            if (tx_push_eff) begin
                tx_wr_q <= tx_wr_q + AW'(1);
            end
            if (tx_pop_fsm) begin
                tx_rd_q <= tx_rd_q + AW'(1);
            end
            tx_cnt_q <= tx_cnt_q + (AW + 1)'(tx_push_eff) - (AW + 1)'(tx_pop_fsm);

            if (rx_push_fsm) begin
                rx_wr_q <= rx_wr_q + AW'(1);
            end
            if (rx_pop_eff) begin
                rx_rd_q <= rx_rd_q + AW'(1);
            end
            rx_cnt_q <= rx_cnt_q + (AW + 1)'(rx_push_fsm) - (AW + 1)'(rx_pop_eff);
        end
    end

    // Storage needs no reset; the read side is gated by the counts.
    always_ff @(posedge Clk_pin) begin
        if (!Reset_pin && tx_push_eff) begin
            tx_mem_q[tx_wr_q] <= Tx_data;
        end
        if (!Reset_pin && rx_push_fsm) begin
            rx_mem_q[rx_wr_q] <= Slv_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Tx_full   = tx_full;
    assign Tx_count  = tx_cnt_q;
    assign Rx_empty  = rx_empty;
    assign Rx_count  = rx_cnt_q;
    assign Rx_data   = rx_empty ? 14'd0 : rx_mem_q[rx_rd_q];
    assign Slv_wdata = wdata_q;
    assign Slv_write = write_q;
    assign Slv_read  = read_q;
    assign Busy      = (state_q != S_IDLE);
    assign Err       = err_q;
    assign Dbg_state = state_q;

endmodule

// File: tb/tb_ahf_slave_link.sv
module tb_ahf_slave_link;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        tx_push, rx_pop, slv_done, slv_dir, err_clr;
    logic [13:0] tx_data, slv_data;
    logic        tx_full, rx_empty, slv_write, slv_read, busy, err;
    logic [AW:0] tx_count, rx_count;
    logic [13:0] rx_data, slv_wdata;
    logic [1:0]  dbg_state;

    ahf_slave_link #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(15)) dut (
        .Clk_pin   (clk),
        .Reset_pin (rst),
        .Tx_push   (tx_push),
        .Tx_data   (tx_data),
        .Tx_full   (tx_full),
        .Tx_count  (tx_count),
        .Rx_pop    (rx_pop),
        .Rx_data   (rx_data),
        .Rx_empty  (rx_empty),
        .Rx_count  (rx_count),
        .Slv_done  (slv_done),
        .Slv_dir   (slv_dir),
        .Slv_data  (slv_data),
        .Slv_wdata (slv_wdata),
        .Slv_write (slv_write),
        .Slv_read  (slv_read),
        .Busy      (busy),
        .Err       (err),
        .Err_clr   (err_clr),
        .Dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [13:0] tx_exp_q[$];
    logic [13:0] rx_exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        dir;
        logic [13:0] data;
        logic        exp_write;
        logic        exp_read;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_tx(input logic [13:0] d);
        tx_data = d;
        tx_push = 1'b1;
        if (tx_exp_q.size() < DEPTH) tx_exp_q.push_back(d);
        tick();
        tx_push = 1'b0;
        check("tx_count_after_push", tx_count, tx_exp_q.size());
    endtask

    task automatic check_tx_strobe();
        logic [13:0] e;
        check("strobe_write", slv_write, 1);
        check("strobe_read_low", slv_read, 0);
        if (tx_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_scoreboard_empty: got write with wdata 0x%0h expected none", slv_wdata);
        end else begin
            e = tx_exp_q.pop_front();
            check("strobe_wdata", slv_wdata, e);
        end
    endtask

    // One complete handshake: Done high for one cycle, then low.
    task automatic handshake(input logic dir, input logic [13:0] data);
        slv_dir  = dir;
        slv_data = data;
        slv_done = 1'b1;
        tick();
        slv_done = 1'b0;
        if (!dir) begin
            check_tx_strobe();
        end else begin
            check("strobe_read", slv_read, 1);
            check("strobe_write_low", slv_write, 0);
            rx_exp_q.push_back(data);
        end
        check("busy_strobe", busy, 1);
        tick();
        check("strobe_one_cycle", {slv_write, slv_read}, 0);
        check("state_wait_drop", dbg_state, 2);
        tick();
        check("busy_back_idle", busy, 0);
        check("tx_count_after_hs", tx_count, tx_exp_q.size());
        check("rx_count_after_hs", rx_count, rx_exp_q.size());
    endtask

    task automatic pop_rx_check();
        logic [13:0] e;
        check("rx_not_empty", rx_empty, 0);
        e = rx_exp_q.pop_front();
        check("rx_data", rx_data, e);
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        check("rx_count_after_pop", rx_count, rx_exp_q.size());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tx_exp_q.delete();
        rx_exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- test body ----------------
    initial begin
        logic [13:0] e;
        tx_push = 0; rx_pop = 0; slv_done = 0; slv_dir = 0; err_clr = 0;
        tx_data = 0; slv_data = 0; rst = 0;

        vecs[0] = '{dir: 1'b0, data: 14'h0001, exp_write: 1'b1, exp_read: 1'b0};
        vecs[1] = '{dir: 1'b1, data: 14'h2AAA, exp_write: 1'b0, exp_read: 1'b1};
        vecs[2] = '{dir: 1'b0, data: 14'h3FFF, exp_write: 1'b1, exp_read: 1'b0};
        vecs[3] = '{dir: 1'b1, data: 14'h0000, exp_write: 1'b0, exp_read: 1'b1};
        for (int i = 4; i < 8; i++) begin
            vecs[i].dir       = 1'(i % 2);
            vecs[i].data      = 14'($urandom_range(0, 16383));
            vecs[i].exp_write = !vecs[i].dir;
            vecs[i].exp_read  = vecs[i].dir;
        end

        // Reset state
        do_reset();
        check("rst_tx_count", tx_count, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_rx_count", rx_count, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_strobes", {slv_write, slv_read}, 0);
        check("rst_wdata", slv_wdata, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);

        // TX path
        push_tx(14'h1234);
        push_tx(14'h0ABC);
        handshake(1'b0, 14'h0);
        check("tx_path_count1", tx_count, 1);
        handshake(1'b0, 14'h0);
        check("tx_path_count0", tx_count, 0);
        check("wdata_held", slv_wdata, 14'h0ABC);

        // RX path
        handshake(1'b1, 14'h3F0F);
        check("rx_path_count1", rx_count, 1);
        pop_rx_check();
        check("rx_path_empty", rx_empty, 1);
        check("rx_path_data0", rx_data, 0);

        // Table-driven transfers
        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].dir) push_tx(vecs[i].data);
            slv_dir  = vecs[i].dir;
            slv_data = vecs[i].data;
            slv_done = 1'b1;
            tick();
            slv_done = 1'b0;
            check("vec_write", slv_write, vecs[i].exp_write);
            check("vec_read", slv_read, vecs[i].exp_read);
            if (!vecs[i].dir) begin
                e = tx_exp_q.pop_front();
                check("vec_wdata", slv_wdata, e);
            end else begin
                rx_exp_q.push_back(vecs[i].data);
            end
            tick();
            tick();
            check("vec_idle", busy, 0);
            if (vecs[i].dir) pop_rx_check();
        end

        // Backpressure: TX empty, slave requesting data
        slv_dir  = 1'b0;
        slv_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_no_strobe", slv_write, 0);
            check("bp_not_busy", busy, 0);
        end
        tx_data = 14'h0005;
        tx_push = 1'b1;
        tx_exp_q.push_back(14'h0005);
        tick();
        tx_push = 1'b0;
        check("bp_write_not_yet", slv_write, 0);
        tick();
        slv_done = 1'b0;
        check_tx_strobe();
        tick();
        tick();
        check("bp_idle", busy, 0);

        // Master push colliding with FSM pop on the same edge
        push_tx(14'h0111);
        slv_dir  = 1'b0;
        slv_done = 1'b1;
        tx_data  = 14'h0222;
        tx_push  = 1'b1;
        tx_exp_q.push_back(14'h0222);
        tick();
        tx_push  = 1'b0;
        slv_done = 1'b0;
        check_tx_strobe();
        check("collide_count", tx_count, 1);
        tick();
        tick();
        handshake(1'b0, 14'h0);

        // Full / wrap on TX
        for (int i = 1; i <= 9; i++) push_tx(14'(i));
        check("tx_full", tx_full, 1);
        check("tx_full_count", tx_count, DEPTH);
        for (int i = 0; i < DEPTH; i++) handshake(1'b0, 14'h0);
        check("tx_drained", tx_count, 0);
        check("tx_not_full", tx_full, 0);

        // Full on RX: ninth slave store must stall
        for (int i = 0; i < DEPTH; i++) handshake(1'b1, 14'(14'h0100 + i));
        slv_dir  = 1'b1;
        slv_data = 14'h1FFF;
        slv_done = 1'b1;
        tick();
        check("rx_full_no_read", slv_read, 0);
        check("rx_full_not_busy", busy, 0);
        check("rx_full_count", rx_count, DEPTH);
        slv_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) pop_rx_check();
        check("rx_drained", rx_empty, 1);

        // Timeout
        push_tx(14'h0777);
        slv_dir  = 1'b0;
        slv_done = 1'b1;
        tick();
        check_tx_strobe();
        tick();
        check("to_enter_wait", dbg_state, 2);
        for (int i = 1; i < 15; i++) begin
            tick();
            check("to_err_low", err, 0);
            check("to_busy", busy, 1);
        end
        tick();
        check("to_err_set", err, 1);
        check("to_back_idle", busy, 0);
        slv_done = 1'b0;
        tick();
        check("to_err_sticky", err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_cleared", err, 0);

        // Reset mid-handshake drops popped word and queued words
        push_tx(14'h0AAA);
        push_tx(14'h0BBB);
        slv_dir  = 1'b0;
        slv_done = 1'b1;
        tick();
        slv_done = 1'b0;
        check_tx_strobe();
        do_reset();
        check("mid_rst_write", slv_write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tx_count", tx_count, 0);
        check("mid_rst_wdata", slv_wdata, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
